// File: rtl/cosim_run_ctrl.sv
// Cosim run controller: staggered per-domain reset release, run-cycle counter,
// kickable watchdog, waveform dump-window gate and sticky finish/fault verdict.
module cosim_run_ctrl #(
  parameter int unsigned CYCLE_WIDTH   = 64,
  parameter int unsigned NUM_RESETS    = 2,
  parameter int unsigned RESET_HOLD    = 2,
  parameter int unsigned RESET_STAGGER = 1,
  parameter int unsigned WDT_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WDT_WIDTH-1:0]   wdt_timeout,
  input  logic                   wdt_kick,
  input  logic                   done_req,
  input  logic [CYCLE_WIDTH-1:0] dump_start,
  input  logic [CYCLE_WIDTH-1:0] dump_end,
  output logic [NUM_RESETS-1:0]  sub_reset,
  output logic [CYCLE_WIDTH-1:0] cycle,
  output logic                   dump_en,
  output logic                   finish,
  output logic                   fatal,
  output logic [1:0]             fatal_code
);

  localparam int unsigned LAST_HOLD = RESET_HOLD + (NUM_RESETS - 1) * RESET_STAGGER;
  localparam int unsigned SEQ_WIDTH = $clog2(LAST_HOLD + 2);

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_WDT  = 2'd1;
  localparam logic [1:0] CODE_DUMP = 2'd2;

  typedef enum logic [1:0] {
    S_SEQ   = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SEQ_WIDTH-1:0]   r_seq_cnt;
  logic [NUM_RESETS-1:0]  r_sub_reset;
  logic [CYCLE_WIDTH-1:0] r_cycle;
  logic [WDT_WIDTH-1:0]   r_wdt_cnt;
  logic                   r_dump_en;
  logic                   r_finish;
  logic                   r_fatal;
  logic [1:0]             r_fatal_code;

  state_t                 w_state_nxt;
  logic [SEQ_WIDTH-1:0]   w_seq_nxt;
  logic [NUM_RESETS-1:0]  w_sub_nxt;
  logic [CYCLE_WIDTH-1:0] w_cycle_inc;
  logic [CYCLE_WIDTH-1:0] w_cycle_nxt;
  logic [WDT_WIDTH-1:0]   w_wdt_inc;
  logic [WDT_WIDTH-1:0]   w_wdt_nxt;
  logic                   w_dump_nxt;
  logic                   w_finish_nxt;
  logic                   w_fatal_nxt;
  logic [1:0]             w_code_nxt;

  // Both counters saturate; a kick clears the watchdog instead of advancing it
  assign w_cycle_inc = (&r_cycle) ? r_cycle : r_cycle + CYCLE_WIDTH'(1);
  assign w_wdt_inc   = wdt_kick ? '0 :
                       ((&r_wdt_cnt) ? r_wdt_cnt : r_wdt_cnt + WDT_WIDTH'(1));

  // State and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_SEQ;
      r_seq_cnt    <= '0;
      r_sub_reset  <= '1;
      r_cycle      <= '0;
      r_wdt_cnt    <= '0;
      r_dump_en    <= 1'b0;
      r_finish     <= 1'b0;
      r_fatal      <= 1'b0;
      r_fatal_code <= CODE_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_seq_cnt    <= w_seq_nxt;
      r_sub_reset  <= w_sub_nxt;
      r_cycle      <= w_cycle_nxt;
      r_wdt_cnt    <= w_wdt_nxt;
      r_dump_en    <= w_dump_nxt;
      r_finish     <= w_finish_nxt;
      r_fatal      <= w_fatal_nxt;
      r_fatal_code <= w_code_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_seq_nxt    = r_seq_cnt;
    w_sub_nxt    = '0;
    w_cycle_nxt  = r_cycle;
    w_wdt_nxt    = r_wdt_cnt;
    w_finish_nxt = r_finish;
    w_fatal_nxt  = r_fatal;
    w_code_nxt   = r_fatal_code;

    case (r_state)
      S_SEQ: begin
        w_seq_nxt = r_seq_cnt + SEQ_WIDTH'(1);
        for (int unsigned i = 0; i < NUM_RESETS; i++) begin
          w_sub_nxt[i] = (32'(r_seq_cnt) < (RESET_HOLD + i * RESET_STAGGER));
        end
        if (32'(r_seq_cnt) >= LAST_HOLD) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_cycle_nxt = w_cycle_inc;
        w_wdt_nxt   = w_wdt_inc;
        if (done_req) begin
          w_state_nxt  = S_DONE;
          w_finish_nxt = 1'b1;
        end else if ((wdt_timeout != '0) && (w_wdt_inc == wdt_timeout)) begin
          w_state_nxt = S_FAULT;
          w_fatal_nxt = 1'b1;
          w_code_nxt  = CODE_WDT;
        end else if ((dump_end != '0) && (w_cycle_inc == dump_end)) begin
          // Fault lands with cycle showing dump_end, one past the last dumped cycle
          w_state_nxt = S_FAULT;
          w_fatal_nxt = 1'b1;
          w_code_nxt  = CODE_DUMP;
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase

    // Registered from next-state values so dump_en lines up with cycle
    w_dump_nxt = (w_state_nxt == S_RUN) && (w_cycle_nxt >= dump_start) &&
                 ((dump_end == '0) || (w_cycle_nxt < dump_end));
  end

  assign sub_reset  = r_sub_reset;
  assign cycle      = r_cycle;
  assign dump_en    = r_dump_en;
  assign finish     = r_finish;
  assign fatal      = r_fatal;
  assign fatal_code = r_fatal_code;

endmodule

// File: tb/tb_cosim_run_ctrl.sv
// Bench for cosim_run_ctrl: directed scenario tasks plus randomized episodes
// checked against a cycle-level behavioural model of the run rules.
module tb_cosim_run_ctrl;

  localparam int unsigned CW    = 12;
  localparam int unsigned NR    = 3;
  localparam int unsigned RH    = 2;
  localparam int unsigned RS    = 3;
  localparam int unsigned WW    = 8;
  localparam int unsigned TLAST = RH + (NR - 1) * RS;
  localparam int unsigned CMAX  = (1 << CW) - 1;
  localparam int unsigned WMAX  = (1 << WW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [WW-1:0] wdt_timeout = '0;
  logic          wdt_kick = 1'b0;
  logic          done_req = 1'b0;
  logic [CW-1:0] dump_start = '0;
  logic [CW-1:0] dump_end = '0;
  logic [NR-1:0] sub_reset;
  logic [CW-1:0] cycle;
  logic          dump_en;
  logic          finish;
  logic          fatal;
  logic [1:0]    fatal_code;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: edges since reset release, then run-cycle bookkeeping
  int unsigned m_k, m_cycle, m_wdt, m_code;
  bit          m_fin, m_fat;

  cosim_run_ctrl #(
    .CYCLE_WIDTH  (CW),
    .NUM_RESETS   (NR),
    .RESET_HOLD   (RH),
    .RESET_STAGGER(RS),
    .WDT_WIDTH    (WW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wdt_timeout(wdt_timeout),
    .wdt_kick   (wdt_kick),
    .done_req   (done_req),
    .dump_start (dump_start),
    .dump_end   (dump_end),
    .sub_reset  (sub_reset),
    .cycle      (cycle),
    .dump_en    (dump_en),
    .finish     (finish),
    .fatal      (fatal),
    .fatal_code (fatal_code)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_bounds(input int unsigned to, input int unsigned ds, input int unsigned de);
    wdt_timeout = WW'(to);
    dump_start  = CW'(ds);
    dump_end    = CW'(de);
    wdt_kick    = 1'b0;
    done_req    = 1'b0;
  endtask

  // Reset, then advance to the first RUN cycle (cycle reads 0)
  task automatic go_run();
    do_reset();
    repeat (TLAST + 1) tick();
  endtask

  task automatic m_step();
    int unsigned newc, neww;
    if (reset) begin
      m_k = 0; m_cycle = 0; m_wdt = 0; m_code = 0; m_fin = 0; m_fat = 0;
    end else if (m_fin || m_fat) begin
      m_k = m_k;
    end else if (m_k <= TLAST) begin
      m_k++;
    end else begin
      newc = (m_cycle == CMAX) ? CMAX : m_cycle + 1;
      neww = wdt_kick ? 0 : ((m_wdt == WMAX) ? WMAX : m_wdt + 1);
      m_cycle = newc;
      m_wdt   = neww;
      if (done_req) m_fin = 1;
      else if (wdt_timeout != 0 && neww == int'(wdt_timeout)) begin m_fat = 1; m_code = 1; end
      else if (dump_end != 0 && newc == int'(dump_end)) begin m_fat = 1; m_code = 2; end
    end
  endtask

  task automatic test_reset();
    set_bounds(0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({sub_reset, cycle, dump_en, finish, fatal, fatal_code} !== {3'b111, CW'(0), 1'b0, 1'b0, 1'b0, 2'd0})
      $display("FAIL reset_values: sub=%b cyc=%0d dump=%b fin=%b fat=%b code=%0d want sub=111 rest 0",
               sub_reset, cycle, dump_en, finish, fatal, fatal_code);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_sequencing();
    logic [NR-1:0] exp_sub;
    int unsigned   exp_cyc;
    set_bounds(0, 0, 0);
    do_reset();
    for (int unsigned k = 1; k <= TLAST + 5; k++) begin
      tick();
      for (int unsigned i = 0; i < NR; i++) exp_sub[i] = (k <= RH + i * RS);
      exp_cyc = (k <= TLAST) ? 0 : k - TLAST - 1;
      n_checks++;
      if (sub_reset !== exp_sub || cycle !== CW'(exp_cyc) || dump_en !== (k > TLAST))
        $display("FAIL seq_k%0d: sub=%b cyc=%0d dump=%b want sub=%b cyc=%0d dump=%b",
                 k, sub_reset, cycle, dump_en, exp_sub, exp_cyc, (k > TLAST));
      else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    set_bounds(5, 0, 0);
    go_run();
    repeat (4) tick();
    n_checks++;
    if (fatal !== 1'b0 || cycle !== CW'(4))
      $display("FAIL wdt_pre: fatal=%b cyc=%0d want 0/4", fatal, cycle);
    else n_pass++;
    tick();
    n_checks++;
    if ({cycle, fatal, fatal_code, finish, dump_en} !== {CW'(5), 1'b1, 2'd1, 1'b0, 1'b0})
      $display("FAIL wdt_fire: cyc=%0d fatal=%b code=%0d fin=%b dump=%b want 5/1/1/0/0",
               cycle, fatal, fatal_code, finish, dump_en);
    else n_pass++;
    wdt_kick = 1'b1;
    done_req = 1'b1;
    repeat (5) tick();
    set_bounds(5, 0, 0);
    n_checks++;
    if (cycle !== CW'(5) || fatal !== 1'b1 || finish !== 1'b0 || sub_reset !== '0)
      $display("FAIL wdt_frozen: cyc=%0d fatal=%b fin=%b sub=%b want 5/1/0/000",
               cycle, fatal, finish, sub_reset);
    else n_pass++;
  endtask

  task automatic test_watchdog_kick();
    for (int unsigned to = 4; to <= 5; to++) begin
      set_bounds(to, 0, 0);
      go_run();
      for (int unsigned j = 0; j < 100; j++) begin
        wdt_kick = ((j % 4) == 3);
        tick();
      end
      wdt_kick = 1'b0;
      n_checks++;
      if (fatal !== 1'b0 || cycle !== CW'(100))
        $display("FAIL wdt_kick_to%0d: fatal=%b cyc=%0d want 0/100", to, fatal, cycle);
      else n_pass++;
    end
  endtask

  task automatic test_dump_window();
    set_bounds(0, 10, 20);
    go_run();
    for (int unsigned j = 0; j < 20; j++) begin
      n_checks++;
      if (dump_en !== (j >= 10) || cycle !== CW'(j))
        $display("FAIL dump_c%0d: dump=%b cyc=%0d want %b/%0d", j, dump_en, cycle, (j >= 10), j);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({cycle, fatal, fatal_code, dump_en} !== {CW'(20), 1'b1, 2'd2, 1'b0})
      $display("FAIL dump_end: cyc=%0d fatal=%b code=%0d dump=%b want 20/1/2/0",
               cycle, fatal, fatal_code, dump_en);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if (cycle !== CW'(20) || fatal_code !== 2'd2)
      $display("FAIL dump_frozen: cyc=%0d code=%0d want 20/2", cycle, fatal_code);
    else n_pass++;
    // Inverted window never opens
    set_bounds(0, 15, 10);
    go_run();
    for (int unsigned j = 0; j <= 10; j++) begin
      n_checks++;
      if (dump_en !== 1'b0)
        $display("FAIL dump_inverted_c%0d: dump=%b want 0", j, dump_en);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_done();
    set_bounds(0, 0, 0);
    go_run();
    repeat (7) tick();
    done_req = 1'b1;
    tick();
    done_req = 1'b0;
    n_checks++;
    if ({finish, fatal, cycle} !== {1'b1, 1'b0, CW'(8)})
      $display("FAIL done: fin=%b fatal=%b cyc=%0d want 1/0/8", finish, fatal, cycle);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if ({finish, cycle, dump_en, sub_reset} !== {1'b1, CW'(8), 1'b0, 3'b000})
      $display("FAIL done_frozen: fin=%b cyc=%0d dump=%b sub=%b want 1/8/0/000",
               finish, cycle, dump_en, sub_reset);
    else n_pass++;
  endtask

  task automatic test_done_vs_wdt();
    set_bounds(5, 0, 0);
    go_run();
    repeat (4) tick();
    done_req = 1'b1;
    tick();
    done_req = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({finish, fatal, fatal_code, cycle} !== {1'b1, 1'b0, 2'd0, CW'(5)})
      $display("FAIL done_vs_wdt: fin=%b fatal=%b code=%0d cyc=%0d want 1/0/0/5",
               finish, fatal, fatal_code, cycle);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] exp_sub;
    int unsigned   exp_cyc;
    set_bounds(3, 0, 0);
    go_run();
    repeat (3) tick();
    n_checks++;
    if (fatal !== 1'b1 || cycle !== CW'(3))
      $display("FAIL mid_pre: fatal=%b cyc=%0d want 1/3", fatal, cycle);
    else n_pass++;
    do_reset();
    n_checks++;
    if ({sub_reset, cycle, dump_en, finish, fatal, fatal_code} !== {3'b111, CW'(0), 1'b0, 1'b0, 1'b0, 2'd0})
      $display("FAIL mid_reset: sub=%b cyc=%0d dump=%b fin=%b fat=%b code=%0d want sub=111 rest 0",
               sub_reset, cycle, dump_en, finish, fatal, fatal_code);
    else n_pass++;
    for (int unsigned k = 1; k <= TLAST + 6; k++) begin
      tick();
      for (int unsigned i = 0; i < NR; i++) exp_sub[i] = (k <= RH + i * RS);
      exp_cyc = (k <= TLAST) ? 0 : ((k - TLAST - 1 > 3) ? 3 : k - TLAST - 1);
      n_checks++;
      if (sub_reset !== exp_sub || cycle !== CW'(exp_cyc) || fatal !== (k >= TLAST + 4))
        $display("FAIL replay_k%0d: sub=%b cyc=%0d fatal=%b want %b/%0d/%b",
                 k, sub_reset, cycle, fatal, exp_sub, exp_cyc, (k >= TLAST + 4));
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    set_bounds(0, 0, 0);
    go_run();
    repeat (CMAX + 10) tick();
    n_checks++;
    if ({cycle, fatal, dump_en} !== {CW'(CMAX), 1'b0, 1'b1})
      $display("FAIL saturate: cyc=%0d fatal=%b dump=%b want %0d/0/1", cycle, fatal, dump_en, CMAX);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [NR-1:0] exp_sub;
    logic          exp_dump;
    bit            running;
    for (int ep = 0; ep < 40; ep++) begin
      set_bounds(($urandom % 4 == 0) ? 0 : $urandom_range(2, 20),
                 $urandom_range(0, 30),
                 ($urandom % 3 == 0) ? 0 : $urandom_range(1, 40));
      reset = 1'b1;
      m_step();
      tick();
      reset = 1'b0;
      for (int n = 0; n < 60; n++) begin
        wdt_kick = ($urandom % 5 == 0);
        done_req = ($urandom % 40 == 0);
        reset    = ($urandom % 100 == 0);
        m_step();
        tick();
        for (int unsigned i = 0; i < NR; i++) exp_sub[i] = (m_k <= RH + i * RS);
        running  = (m_k > TLAST) && !m_fin && !m_fat;
        exp_dump = running && (m_cycle >= dump_start) && (dump_end == 0 || m_cycle < dump_end);
        n_checks++;
        if ({sub_reset, cycle, dump_en, finish, fatal, fatal_code} !==
            {exp_sub, CW'(m_cycle), exp_dump, m_fin, m_fat, 2'(m_code)})
          $display("FAIL rand_ep%0d_n%0d: sub=%b cyc=%0d dump=%b fin=%b fat=%b code=%0d want sub=%b cyc=%0d dump=%b fin=%b fat=%b code=%0d",
                   ep, n, sub_reset, cycle, dump_en, finish, fatal, fatal_code,
                   exp_sub, m_cycle, exp_dump, m_fin, m_fat, m_code);
        else n_pass++;
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sequencing();
    test_watchdog();
    test_watchdog_kick();
    test_dump_window();
    test_done();
    test_done_vs_wdt();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cosim_run_ctrl.md
# cosim_run_ctrl

Synthesizable run controller for the T1 cosim test harness: sequences per-domain reset release, counts run cycles, and runs a kickable watchdog. Also gates a waveform-dump window and reports a sticky finish/fault verdict. It takes over the cycle, watchdog and dump-window bookkeeping from the behavioural clock generator, so DPI only has to poll one status word. It sits between the clock/reset source and the DUT domains, and is parametrised in reset-channel count, stagger and counter widths.

## Interface
- CYCLE_WIDTH, 64, width of cycle counter and dump bounds
- NUM_RESETS, 2, number of downstream reset channels (>=1)
- RESET_HOLD, 2, cycles channel 0 stays in reset after `reset` is sampled low (>=1)
- RESET_STAGGER, 1, extra hold cycles per successive channel (>=0)
- WDT_WIDTH, 32, watchdog counter/threshold width
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wdt_timeout  in  WDT_WIDTH  consecutive unkicked RUN cycles allowed; 0 disables watchdog
- wdt_kick  in  1  restarts watchdog count
- done_req  in  1  test reports successful completion
- dump_start  in  CYCLE_WIDTH  first cycle with dump_en high
- dump_end  in  CYCLE_WIDTH  cycle that raises fault; 0 disables
- sub_reset  out  NUM_RESETS  per-domain active-high reset
- cycle  out  CYCLE_WIDTH  run-cycle count
- dump_en  out  1  waveform dump enable
- finish  out  1  sticky success
- fatal  out  1  sticky failure
- fatal_code  out  2  1 = watchdog timeout, 2 = dump_end reached, 0 otherwise

## Operation
- FSM states: SEQ, RUN, DONE, FAULT. Reset forces SEQ.
- SEQ
  - seq_cnt counts cycles since `reset` was sampled low.
  - sub_reset[i] deasserts once seq_cnt reaches RESET_HOLD + i*RESET_STAGGER.
  - Transition to RUN on the same edge the last channel deasserts.
- RUN
  - cycle increments each cycle and saturates at all-ones.
  - wdt_cnt clears on a kick and otherwise increments.
  - Checks are evaluated on the sampled values in this priority order:
    - done_req -> DONE; finish=1.
    - wdt_timeout != 0 and the incremented wdt_cnt == wdt_timeout -> FAULT; fatal_code=1.
    - dump_end != 0 and cycle == dump_end -> FAULT; fatal_code=2.
- DONE / FAULT
  - Terminal until reset.
  - cycle frozen, sub_reset held low, dump_en low.
  - done_req, kicks and bounds are ignored.
- dump_en = (state==RUN) && cycle >= dump_start && (dump_end==0 || cycle < dump_end).
  - Registered: computed from the next-state values so it aligns with the cycle output.
- Comparisons are unsigned. WDT_WIDTH wraps are impossible because a fault fires first.
  - With the watchdog disabled, wdt_cnt saturates.

## Timing
- All outputs are registered. The cycle after reset is sampled high shows:
  - sub_reset all 1, cycle 0, dump_en 0, finish 0, fatal 0, fatal_code 0.
- Mid-operation reset, in any state, returns to these values on the next edge and restarts the sequence.
- sub_reset[i] is observed high for exactly RESET_HOLD + i*RESET_STAGGER cycles after the first edge with reset low.
- First RUN cycle shows cycle=0, with sub_reset all 0 in the same cycle.
- done_req/kick/fault conditions sampled in cycle n take effect on outputs in cycle n+1.
- A kick in the same cycle the count would hit threshold prevents the fault.
- dump_start=0 gives dump_en=1 from the first RUN cycle.
- dump_start >= dump_end (nonzero end) means dump_en never rises.

## Test plan
- Sequencing, NUM_RESETS=3, RESET_HOLD=2, RESET_STAGGER=3; release reset:
  - sub_reset[0..2] fall after 2, 5 and 8 cycles.
  - cycle=0 in the cycle where sub_reset[2] first reads 0.
- Watchdog, wdt_timeout=5, no kicks:
  - fatal=1 and fatal_code=1 visible when cycle reads 5, and cycle stays 5 thereafter.
  - Repeat with a kick every 4 cycles for 100 cycles: fatal stays 0.
- Dump window, dump_start=10, dump_end=20:
  - dump_en is high exactly for cycle 10..19.
  - fatal_code=2 appears with cycle=20 frozen.
- Completion: done_req pulsed at cycle 7 -> finish=1 and cycle=8 frozen.
  - done_req in the same cycle the watchdog threshold is hit -> finish=1, fatal=0.
- Reset mid-operation: assert reset for 1 cycle while in FAULT -> all outputs return to reset values and the sequence replays identically.
- wdt_timeout=0, dump_end=0, 10^6 cycles -> no fault; cycle=999999 at end.
